// File: rtl/wb_stage.sv
// Write-back stage: latches one retiring instruction per cycle from MEM and commits it
// (GPR write, CSR write, ertn return or exception entry), raising the pipeline flush.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    input  logic        ms_csr_re,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        ms_ertn,
    input  logic        ms_int,
    input  logic        ms_ex,
    input  logic [5:0]  ms_ecode,
    input  logic [8:0]  ms_esubcode,
    input  logic [31:0] ms_vaddr,
    input  logic [31:0] csr_rvalue,
    output logic        csr_re,
    output logic [13:0] csr_num,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_vaddr,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    output logic        ws_flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_we,
    output logic [4:0]  ws_fwd_addr,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [63:0] retire_cnt
);

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        intr;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
    } ws_payload_t;

    // Handshake: MEM->WB transfers at an edge where ms_valid & ws_allowin; WB never
    // stalls, so ws_allowin is always high and a flushing WB simply drops the transfer.
    logic        ws_ready_go;
    logic        ws_valid_q, ws_valid_d;
    ws_payload_t payload_q, payload_d;
    logic [63:0] retire_cnt_q, retire_cnt_d;
    logic        ex;
    logic        commit;
    logic [31:0] wdata_sel;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid_q | ws_ready_go;

    always_comb begin
        ex        = ws_valid_q & (payload_q.intr | payload_q.ex);
        commit    = ws_valid_q & !ex;
        wdata_sel = payload_q.csr_re ? csr_rvalue : payload_q.rf_wdata;
    end

    assign wb_ex       = ex;
    assign wb_ecode    = payload_q.intr ? 6'h00 : payload_q.ecode;
    assign wb_esubcode = payload_q.intr ? 9'h000 : payload_q.esubcode;
    assign wb_vaddr    = payload_q.vaddr;
    assign wb_pc       = payload_q.pc;
    assign ertn_flush  = ws_valid_q & payload_q.ertn & !ex;
    assign ws_flush    = wb_ex | ertn_flush;

    assign csr_re     = ws_valid_q & payload_q.csr_re;
    assign csr_num    = payload_q.csr_num;
    assign csr_we     = commit & payload_q.csr_we;
    assign csr_wmask  = payload_q.csr_wmask;
    assign csr_wvalue = payload_q.csr_wvalue;

    // r0 is hard-wired zero, so a write to it must never reach the file or the bypass.
    assign rf_we    = commit & payload_q.rf_we & (payload_q.rf_waddr != 5'd0);
    assign rf_waddr = payload_q.rf_waddr;
    assign rf_wdata = wdata_sel;

    assign ws_fwd_we   = rf_we;
    assign ws_fwd_addr = rf_waddr;
    assign ws_fwd_data = rf_wdata;

    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign retire_cnt = retire_cnt_q;

    always_comb begin
        ws_valid_d   = ws_valid_q;
        payload_d    = payload_q;
        retire_cnt_d = retire_cnt_q + {63'd0, commit};
        if (ws_flush) begin
            ws_valid_d = 1'b0;
        end else if (ms_valid & ws_allowin) begin
            ws_valid_d          = 1'b1;
            payload_d.pc         = ms_pc;
            payload_d.rf_we      = ms_rf_we;
            payload_d.rf_waddr   = ms_rf_waddr;
            payload_d.rf_wdata   = ms_rf_wdata;
            payload_d.csr_re     = ms_csr_re;
            payload_d.csr_we     = ms_csr_we;
            payload_d.csr_num    = ms_csr_num;
            payload_d.csr_wmask  = ms_csr_wmask;
            payload_d.csr_wvalue = ms_csr_wvalue;
            payload_d.ertn       = ms_ertn;
            payload_d.intr       = ms_int;
            payload_d.ex         = ms_ex;
            payload_d.ecode      = ms_ecode;
            payload_d.esubcode   = ms_esubcode;
            payload_d.vaddr      = ms_vaddr;
        end else begin
            ws_valid_d = ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q   <= 1'b0;
            payload_q    <= '0;
            retire_cnt_q <= 64'd0;
        end else begin
            ws_valid_q   <= ws_valid_d;
            payload_q    <= payload_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: each task drives one scenario and checks the commit
// outputs against hand-computed values.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_csr_re;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask;
    logic [31:0] ms_csr_wvalue;
    logic        ms_ertn;
    logic        ms_int;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic [31:0] ms_vaddr;
    logic [31:0] csr_rvalue;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic        ws_flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_we;
    logic [4:0]  ws_fwd_addr;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [63:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
        .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue), .ms_ertn(ms_ertn),
        .ms_int(ms_int), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
        .ms_vaddr(ms_vaddr), .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_num(csr_num),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_pc(wb_pc),
        .ertn_flush(ertn_flush), .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ws_fwd_we(ws_fwd_we), .ws_fwd_addr(ws_fwd_addr),
        .ws_fwd_data(ws_fwd_data), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .retire_cnt(retire_cnt)
    );

    task automatic clear_ms();
        ms_valid = 0; ms_pc = 0; ms_rf_we = 0; ms_rf_waddr = 0; ms_rf_wdata = 0;
        ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = 0; ms_csr_wmask = 0; ms_csr_wvalue = 0;
        ms_ertn = 0; ms_int = 0; ms_ex = 0; ms_ecode = 0; ms_esubcode = 0; ms_vaddr = 0;
    endtask

    // Fields are set by the caller before this; the instruction is presented at the
    // falling edge, latched at the next rising edge, and the call returns 1 ns later.
    task automatic present_and_latch();
        @(negedge clk);
        ms_valid = 1'b1;
        @(posedge clk);
        #1;
        ms_valid = 1'b0;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_ms();
        csr_rvalue = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ws_allowin !== 1'b1) begin n_errors++; $display("FAIL reset_allowin: got %h exp 1", ws_allowin); end
        n_checks++; if ({csr_re, csr_we, wb_ex, ertn_flush, ws_flush, rf_we, ws_fwd_we} !== 7'b0) begin n_errors++; $display("FAIL reset_strobes: got %b exp 0", {csr_re, csr_we, wb_ex, ertn_flush, ws_flush, rf_we, ws_fwd_we}); end
        n_checks++; if (debug_wb_rf_we !== 4'h0) begin n_errors++; $display("FAIL reset_dbg_we: got %h exp 0", debug_wb_rf_we); end
        n_checks++; if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL reset_retire: got %0d exp 0", retire_cnt); end
        n_checks++; if ({wb_pc, rf_wdata, wb_vaddr, csr_wvalue} !== 128'd0) begin n_errors++; $display("FAIL reset_data: got %h exp 0", {wb_pc, rf_wdata, wb_vaddr, csr_wvalue}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        clear_ms();
        ms_pc = 32'h1c000000; ms_rf_we = 1; ms_rf_waddr = 5; ms_rf_wdata = 32'h1234;
        present_and_latch();
        n_checks++; if (rf_we !== 1'b1) begin n_errors++; $display("FAIL alu_rf_we: got %h exp 1", rf_we); end
        n_checks++; if (rf_wdata !== 32'h1234) begin n_errors++; $display("FAIL alu_rf_wdata: got %h exp 1234", rf_wdata); end
        n_checks++; if (debug_wb_rf_we !== 4'hF) begin n_errors++; $display("FAIL alu_dbg_we: got %h exp f", debug_wb_rf_we); end
        n_checks++; if (debug_wb_pc !== 32'h1c000000) begin n_errors++; $display("FAIL alu_dbg_pc: got %h exp 1c000000", debug_wb_pc); end
        n_checks++; if ({ws_fwd_we, ws_fwd_addr, ws_fwd_data} !== {1'b1, 5'd5, 32'h1234}) begin n_errors++; $display("FAIL alu_fwd: got %h exp %h", {ws_fwd_we, ws_fwd_addr, ws_fwd_data}, {1'b1, 5'd5, 32'h1234}); end
        n_checks++; if (ws_flush !== 1'b0) begin n_errors++; $display("FAIL alu_flush: got %h exp 0", ws_flush); end
        n_checks++; if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL alu_retire_before: got %0d exp 0", retire_cnt); end
        next_edge();
        n_checks++; if (retire_cnt !== 64'd1) begin n_errors++; $display("FAIL alu_retire_after: got %0d exp 1", retire_cnt); end
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL alu_idle_rf_we: got %h exp 0", rf_we); end
    endtask

    task automatic test_csrxchg();
        clear_ms();
        ms_pc = 32'h1c000004; ms_rf_we = 1; ms_rf_waddr = 6; ms_rf_wdata = 32'hDEAD;
        ms_csr_re = 1; ms_csr_we = 1; ms_csr_num = 14'h30;
        ms_csr_wmask = 32'h0000FFFF; ms_csr_wvalue = 32'hABCD;
        csr_rvalue = 32'h5555;
        present_and_latch();
        n_checks++; if (rf_wdata !== 32'h5555) begin n_errors++; $display("FAIL csr_rf_wdata: got %h exp 5555", rf_wdata); end
        n_checks++; if ({csr_re, csr_we, wb_ex} !== 3'b110) begin n_errors++; $display("FAIL csr_strobes: got %b exp 110", {csr_re, csr_we, wb_ex}); end
        n_checks++; if ({csr_num, csr_wmask, csr_wvalue} !== {14'h30, 32'h0000FFFF, 32'hABCD}) begin n_errors++; $display("FAIL csr_fields: got %h exp %h", {csr_num, csr_wmask, csr_wvalue}, {14'h30, 32'h0000FFFF, 32'hABCD}); end
        next_edge();
        csr_rvalue = 32'h0;
        n_checks++; if (retire_cnt !== 64'd2) begin n_errors++; $display("FAIL csr_retire: got %0d exp 2", retire_cnt); end
    endtask

    task automatic test_ale();
        clear_ms();
        ms_pc = 32'h1c000008; ms_rf_we = 1; ms_rf_waddr = 7; ms_rf_wdata = 32'h99;
        ms_csr_we = 1; ms_csr_num = 14'h1;
        ms_ex = 1; ms_ecode = 6'h09; ms_vaddr = 32'h1c000003;
        present_and_latch();
        n_checks++; if ({wb_ex, ws_flush, ertn_flush} !== 3'b110) begin n_errors++; $display("FAIL ale_ex_flush: got %b exp 110", {wb_ex, ws_flush, ertn_flush}); end
        n_checks++; if (wb_ecode !== 6'h09) begin n_errors++; $display("FAIL ale_ecode: got %h exp 09", wb_ecode); end
        n_checks++; if (wb_vaddr !== 32'h1c000003) begin n_errors++; $display("FAIL ale_vaddr: got %h exp 1c000003", wb_vaddr); end
        n_checks++; if (wb_pc !== 32'h1c000008) begin n_errors++; $display("FAIL ale_pc: got %h exp 1c000008", wb_pc); end
        n_checks++; if ({rf_we, csr_we, debug_wb_rf_we} !== 6'b0) begin n_errors++; $display("FAIL ale_no_commit: got %b exp 0", {rf_we, csr_we, debug_wb_rf_we}); end
        // A valid instruction offered during the flush cycle must be dropped.
        clear_ms();
        ms_pc = 32'h1c00000c; ms_rf_we = 1; ms_rf_waddr = 8; ms_rf_wdata = 32'h88;
        present_and_latch();
        n_checks++; if ({rf_we, wb_ex, ws_flush} !== 3'b000) begin n_errors++; $display("FAIL ale_drop: got %b exp 000", {rf_we, wb_ex, ws_flush}); end
        n_checks++; if (retire_cnt !== 64'd2) begin n_errors++; $display("FAIL ale_retire: got %0d exp 2", retire_cnt); end
        next_edge();
        n_checks++; if (retire_cnt !== 64'd2) begin n_errors++; $display("FAIL ale_retire_drop: got %0d exp 2", retire_cnt); end
    endtask

    task automatic test_int();
        clear_ms();
        ms_pc = 32'h1c000010; ms_int = 1; ms_ex = 1; ms_ecode = 6'h0B; ms_esubcode = 9'h3;
        present_and_latch();
        n_checks++; if (wb_ex !== 1'b1) begin n_errors++; $display("FAIL int_ex: got %h exp 1", wb_ex); end
        n_checks++; if ({wb_ecode, wb_esubcode} !== 15'd0) begin n_errors++; $display("FAIL int_codes: got %h exp 0", {wb_ecode, wb_esubcode}); end
        next_edge();
        n_checks++; if (retire_cnt !== 64'd2) begin n_errors++; $display("FAIL int_retire: got %0d exp 2", retire_cnt); end
    endtask

    task automatic test_ertn();
        clear_ms();
        ms_pc = 32'h1c000014; ms_ertn = 1;
        present_and_latch();
        n_checks++; if ({ertn_flush, ws_flush, wb_ex} !== 3'b110) begin n_errors++; $display("FAIL ertn_flush: got %b exp 110", {ertn_flush, ws_flush, wb_ex}); end
        next_edge();
        n_checks++; if ({ertn_flush, ws_flush} !== 2'b00) begin n_errors++; $display("FAIL ertn_one_cycle: got %b exp 00", {ertn_flush, ws_flush}); end
        n_checks++; if (retire_cnt !== 64'd3) begin n_errors++; $display("FAIL ertn_retire: got %0d exp 3", retire_cnt); end
        clear_ms();
        ms_pc = 32'h1c000018; ms_ertn = 1; ms_ex = 1; ms_ecode = 6'h0D;
        present_and_latch();
        n_checks++; if ({ertn_flush, wb_ex, ws_flush} !== 3'b011) begin n_errors++; $display("FAIL ertn_ex: got %b exp 011", {ertn_flush, wb_ex, ws_flush}); end
        next_edge();
        n_checks++; if (retire_cnt !== 64'd3) begin n_errors++; $display("FAIL ertn_ex_retire: got %0d exp 3", retire_cnt); end
    endtask

    task automatic test_r0();
        clear_ms();
        ms_pc = 32'h1c00001c; ms_rf_we = 1; ms_rf_waddr = 0; ms_rf_wdata = 32'h77;
        present_and_latch();
        n_checks++; if ({rf_we, ws_fwd_we, debug_wb_rf_we} !== 6'b0) begin n_errors++; $display("FAIL r0_we: got %b exp 0", {rf_we, ws_fwd_we, debug_wb_rf_we}); end
        next_edge();
        n_checks++; if (retire_cnt !== 64'd4) begin n_errors++; $display("FAIL r0_retire: got %0d exp 4", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_ms();
        ms_pc = 32'h1c000020; ms_rf_we = 1; ms_rf_waddr = 10; ms_rf_wdata = 32'hA0A0;
        present_and_latch();
        n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA0A0}) begin n_errors++; $display("FAIL b2b_first: got %h exp %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd10, 32'hA0A0}); end
        clear_ms();
        ms_pc = 32'h1c000024; ms_rf_we = 1; ms_rf_waddr = 11; ms_rf_wdata = 32'hB0B0;
        present_and_latch();
        n_checks++; if ({rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} !== {1'b1, 5'd11, 32'hB0B0}) begin n_errors++; $display("FAIL b2b_second: got %h exp %h", {rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, {1'b1, 5'd11, 32'hB0B0}); end
        n_checks++; if (retire_cnt !== 64'd5) begin n_errors++; $display("FAIL b2b_retire_mid: got %0d exp 5", retire_cnt); end
        next_edge();
        n_checks++; if (retire_cnt !== 64'd6) begin n_errors++; $display("FAIL b2b_retire: got %0d exp 6", retire_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_ms();
        ms_pc = 32'h1c000028; ms_rf_we = 1; ms_rf_waddr = 3; ms_rf_wdata = 32'h33;
        present_and_latch();
        n_checks++; if (rf_we !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre: got %h exp 1", rf_we); end
        // Reset arrives together with another valid instruction; reset must win.
        clear_ms();
        ms_pc = 32'h1c00002c; ms_rf_we = 1; ms_rf_waddr = 4; ms_rf_wdata = 32'h44;
        @(negedge clk);
        reset = 1'b1;
        ms_valid = 1'b1;
        next_edge();
        ms_valid = 1'b0;
        n_checks++; if ({rf_we, ws_fwd_we, csr_re, csr_we, wb_ex, ertn_flush, ws_flush} !== 7'b0) begin n_errors++; $display("FAIL rst_mid_strobes: got %b exp 0", {rf_we, ws_fwd_we, csr_re, csr_we, wb_ex, ertn_flush, ws_flush}); end
        n_checks++; if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL rst_mid_retire: got %0d exp 0", retire_cnt); end
        n_checks++; if ({wb_pc, rf_waddr, rf_wdata} !== 69'd0) begin n_errors++; $display("FAIL rst_mid_data: got %h exp 0", {wb_pc, rf_waddr, rf_wdata}); end
        @(negedge clk);
        reset = 1'b0;
        next_edge();
        n_checks++; if ({rf_we, retire_cnt} !== 65'd0) begin n_errors++; $display("FAIL rst_mid_after: got %h exp 0", {rf_we, retire_cnt}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_csrxchg();
        test_ale();
        test_int();
        test_ertn();
        test_r0();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
